// File: rtl/mux_scan_nto1_if.sv
// Channel bus for mux_scan_nto1: per-channel data and scan controls in, selected word and status out.
interface mux_scan_nto1_if #(
    parameter int WIDTH = 4,
    parameter int N     = 16,
    parameter int SEL_W = 4
) ();
    logic [N*WIDTH-1:0] data_in;
    logic               mode;
    logic [SEL_W-1:0]   sel_in;
    logic [N-1:0]       ch_mask;
    logic               ce;
    logic [WIDTH-1:0]   z;
    logic [SEL_W-1:0]   ch;
    logic               step;
    logic               sel_err;

    modport master (
        output data_in, mode, sel_in, ch_mask, ce,
        input  z, ch, step, sel_err
    );

    modport slave (
        input  data_in, mode, sel_in, ch_mask, ce,
        output z, ch, step, sel_err
    );
endinterface

// File: rtl/mux_scan_nto1.sv
// Registered N:1 word mux with manual select and masked auto-scan with per-channel dwell.
// Optional MUX_SCAN_BLANK_EN blanks z on a scan step and the cycle after it.
module mux_scan_nto1 #(
    parameter int WIDTH   = 4,
    parameter int N       = 16,
    parameter int SEL_W   = 4,
    parameter int DWELL   = 1000,
    parameter int DWELL_W = 10
) (
    input  logic          clk,
    input  logic          rstb,
    mux_scan_nto1_if.slave bus
);

    localparam logic [0:0] MANUAL = 1'b0;
    localparam logic [0:0] SCAN   = 1'b1;
    localparam logic [DWELL_W-1:0] TERM = DWELL_W'(DWELL - 1);

    logic [0:0]         state, state_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [SEL_W-1:0]   ch_q, ch_d, nxt;
    logic               step_q, step_d;
    logic               sel_err_q, sel_err_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               sel_ok, mask_zero, blank_d;

    // Rotate the mask so bit 0 is the channel after cur, take the lowest set bit, rotate back.
    function automatic logic [SEL_W-1:0] next_ch(input logic [N-1:0] mask,
                                                 input logic [SEL_W-1:0] cur);
        logic [N-1:0] rot;
        int sh;
        int pos;
        sh = int'(cur) + 1;
        if (sh >= N) sh = 0;
        rot = (sh == 0) ? mask : ((mask >> sh) | (mask << (N - sh)));
        pos = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = i;
        end
        pos = pos + sh;
        if (pos >= N) pos = pos - N;
        return SEL_W'(pos);
    endfunction

    assign sel_ok    = ({1'b0, bus.sel_in} < (SEL_W + 1)'(N));
    assign mask_zero = (bus.ch_mask == '0);
    assign nxt       = next_ch(bus.ch_mask, ch_q);

    always_comb begin
        state_d   = bus.mode ? SCAN : MANUAL;
        cnt_d     = cnt;
        ch_d      = ch_q;
        step_d    = 1'b0;
        sel_err_d = 1'b0;
        if (!bus.mode) begin
            cnt_d = '0;
            if (sel_ok) ch_d = bus.sel_in;
            else        sel_err_d = 1'b1;
        end else if (state == MANUAL) begin
            // Entering scan: keep ch, start a full dwell.
            cnt_d = '0;
        end else if (mask_zero) begin
            cnt_d = '0;
        end else if (bus.ce) begin
            if (cnt == TERM) begin
                cnt_d  = '0;
                ch_d   = nxt;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end

        blank_d = sel_err_d || (bus.mode && mask_zero);
`ifdef MUX_SCAN_BLANK_EN
        blank_d = blank_d || (bus.mode && (step_d || step_q));
`endif
        z_d = blank_d ? '0 : bus.data_in[int'(ch_q) * WIDTH +: WIDTH];
    end

    // Register stage: control and output word.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= MANUAL;
            cnt       <= '0;
            ch_q      <= '0;
            step_q    <= 1'b0;
            sel_err_q <= 1'b0;
            z_q       <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ch_q      <= ch_d;
            step_q    <= step_d;
            sel_err_q <= sel_err_d;
            z_q       <= z_d;
        end
    end

    assign bus.z       = z_q;
    assign bus.ch      = ch_q;
    assign bus.step    = step_q;
    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: a 16-channel instance for select/scan and a 10-channel one for range errors.
module tb_mux_scan_nto1;

    logic clk = 1'b0;
    logic rstb;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_scan_nto1_if #(.WIDTH(4), .N(16), .SEL_W(4)) ia ();
    mux_scan_nto1_if #(.WIDTH(4), .N(10), .SEL_W(4)) ib ();

    mux_scan_nto1 #(.WIDTH(4), .N(16), .SEL_W(4), .DWELL(4), .DWELL_W(3)) u_a (
        .clk(clk), .rstb(rstb), .bus(ia)
    );
    mux_scan_nto1 #(.WIDTH(4), .N(10), .SEL_W(4), .DWELL(4), .DWELL_W(3)) u_b (
        .clk(clk), .rstb(rstb), .bus(ib)
    );

    // Expected ch after each edge of the skip/wrap scan, index 0 = entry edge.
    int exp_scan_ch [13] = '{0, 0, 0, 0, 2, 2, 2, 2, 15, 15, 15, 15, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ez;

        // Reset with random inputs
        rstb = 1'b0;
        ia.data_in = {$urandom, $urandom};
        ia.mode    = 1'($urandom);
        ia.sel_in  = 4'($urandom);
        ia.ch_mask = 16'($urandom);
        ia.ce      = 1'($urandom);
        ib.data_in = 40'({$urandom, $urandom});
        ib.mode    = 1'($urandom);
        ib.sel_in  = 4'($urandom);
        ib.ch_mask = 10'($urandom);
        ib.ce      = 1'($urandom);
        tick(); tick(); tick();
        check("rst_z", 32'(ia.z), 0);
        check("rst_ch", 32'(ia.ch), 0);
        check("rst_step", 32'(ia.step), 0);
        check("rst_sel_err", 32'(ia.sel_err), 0);
        check("rst_b_ch", 32'(ib.ch), 0);

        // Manual select
        ia.data_in = 64'hFEDC_BA98_7654_3210;
        ia.mode    = 1'b0;
        ia.sel_in  = 4'd5;
        ia.ch_mask = 16'h0000;
        ia.ce      = 1'b1;
        ib.data_in = 40'h98_7654_3210;
        ib.mode    = 1'b0;
        ib.sel_in  = 4'd6;
        ib.ch_mask = 10'h3FF;
        ib.ce      = 1'b1;
        rstb = 1'b1;
        tick();
        check("man_ch5", 32'(ia.ch), 5);
        check("man_z_lag", 32'(ia.z), 0);
        tick();
        check("man_z5", 32'(ia.z), 5);
        ia.sel_in = 4'd9;
        tick();
        check("man_ch9", 32'(ia.ch), 9);
        check("man_z_still5", 32'(ia.z), 5);
        tick();
        check("man_z9", 32'(ia.z), 9);
        ia.data_in[9*4 +: 4] = 4'hA;
        tick();
        check("man_data_chg", 32'(ia.z), 32'hA);
        ia.data_in = 64'hFEDC_BA98_7654_3210;

        // Out of range on the 10-channel instance
        check("oor_b_ch6", 32'(ib.ch), 6);
        check("oor_b_z6", 32'(ib.z), 6);
        ib.sel_in = 4'd12;
        tick();
        check("oor_err", 32'(ib.sel_err), 1);
        check("oor_z0", 32'(ib.z), 0);
        check("oor_ch_hold", 32'(ib.ch), 6);
        tick();
        check("oor_err2", 32'(ib.sel_err), 1);
        check("oor_z0_2", 32'(ib.z), 0);
        ib.sel_in = 4'd3;
        tick();
        check("oor_clr", 32'(ib.sel_err), 0);
        check("oor_ch3", 32'(ib.ch), 3);
        tick();
        check("oor_z3", 32'(ib.z), 3);

        // Scan with skip and wrap, DWELL=4
        ia.sel_in = 4'd0;
        tick(); tick();
        check("scan_pre_ch0", 32'(ia.ch), 0);
        ia.mode    = 1'b1;
        ia.ch_mask = 16'h8005;
        tick();
        check("scan_entry_ch", 32'(ia.ch), 0);
        check("scan_entry_step", 32'(ia.step), 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            ez = 32'(exp_scan_ch[k-1]);
`ifdef MUX_SCAN_BLANK_EN
            if (k >= 4 && (k % 4 == 0 || k % 4 == 1)) ez = 0;
`endif
            check($sformatf("scan_ch_k%0d", k), 32'(ia.ch), 32'(exp_scan_ch[k]));
            check($sformatf("scan_step_k%0d", k), 32'(ia.step), (k % 4 == 0) ? 1 : 0);
            check($sformatf("scan_z_k%0d", k), 32'(ia.z), ez);
        end

        // ce low for 3 cycles mid-dwell stretches the dwell by 3
        tick(); tick();
        check("ce_pre_step", 32'(ia.step), 0);
        ia.ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ce_frz_step%0d", k), 32'(ia.step), 0);
            check($sformatf("ce_frz_ch%0d", k), 32'(ia.ch), 0);
        end
        ia.ce = 1'b1;
        tick();
        check("ce_late_nostep", 32'(ia.step), 0);
        check("ce_late_ch0", 32'(ia.ch), 0);
        tick();
        check("ce_late_step", 32'(ia.step), 1);
        check("ce_late_ch2", 32'(ia.ch), 2);

        // mode drops on the terminal-count edge
        tick(); tick(); tick();
        check("col_pre_step", 32'(ia.step), 0);
        ia.mode   = 1'b0;
        ia.sel_in = 4'd7;
        tick();
        check("col_ch7", 32'(ia.ch), 7);
        check("col_step0", 32'(ia.step), 0);
        check("col_z_old", 32'(ia.z), 2);
        tick();
        check("col_z7", 32'(ia.z), 7);

        // Single enabled channel equal to ch
        ia.sel_in = 4'd4;
        tick();
        check("one_pre_ch4", 32'(ia.ch), 4);
        ia.mode    = 1'b1;
        ia.ch_mask = 16'h0010;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            ez = 4;
`ifdef MUX_SCAN_BLANK_EN
            if (k % 4 == 0 || (k >= 4 && k % 4 == 1)) ez = 0;
`endif
            check($sformatf("one_ch_k%0d", k), 32'(ia.ch), 4);
            check($sformatf("one_step_k%0d", k), 32'(ia.step), (k % 4 == 0) ? 1 : 0);
            check($sformatf("one_z_k%0d", k), 32'(ia.z), ez);
        end

        // Empty mask in scan
        ia.ch_mask = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("empty_z%0d", k), 32'(ia.z), 0);
            check($sformatf("empty_step%0d", k), 32'(ia.step), 0);
            check($sformatf("empty_ch%0d", k), 32'(ia.ch), 4);
        end

        // Reset mid-scan
        ia.ch_mask = 16'h0010;
        tick();
        check("midscan_z4", 32'(ia.z), 4);
        rstb = 1'b0;
        tick();
        check("mid_rst_z", 32'(ia.z), 0);
        check("mid_rst_ch", 32'(ia.ch), 0);
        check("mid_rst_step", 32'(ia.step), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
